// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Brief    : Instruction fetch unit with a sequential PC generator, up to
//            QDEPTH outstanding memory requests, and a QDEPTH-entry
//            {pc, instr} queue feeding the decoder. A redirect flushes the
//            queue and discards responses to requests already in flight.
// Options  : define IFU_TRACE_EN to print decode handshakes and redirects.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h00000000,
  parameter logic [XLEN-1:0] IMEM_START = 32'h00000000,
  parameter logic [XLEN-1:0] IMEM_END   = 32'h00000064,
  parameter int unsigned     QDEPTH     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr,
  input  logic            dec_ready,
  output logic            halted
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

  // Window and alignment check on an XLEN+1-bit address so that a pc+4 that
  // carried out of XLEN bits is always rejected.
  function automatic logic is_legal(input logic [XLEN:0] a);
    return (a >= {1'b0, IMEM_START}) && (a <= {1'b0, IMEM_END}) && (a[1:0] == 2'b00);
  endfunction

  // Sequencer state
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_halted;

  // Decode queue
  logic [XLEN-1:0] r_q_pc    [QDEPTH];
  logic [XLEN-1:0] r_q_instr [QDEPTH];
  logic [PW-1:0]   r_q_head;
  logic [PW-1:0]   r_q_tail;
  logic [CW-1:0]   r_count;

  // In-flight pc FIFO; its occupancy always equals r_inflight, including
  // requests whose responses are marked for dropping.
  logic [XLEN-1:0] r_f_pc [QDEPTH];
  logic [PW-1:0]   r_f_head;
  logic [PW-1:0]   r_f_tail;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;

  logic [CW:0]     w_occupancy;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  logic [XLEN:0]   w_next_pc;
  logic [CW-1:0]   w_fire_n;
  logic [CW-1:0]   w_rsp_n;
  logic [CW-1:0]   w_keep_n;
  logic [CW-1:0]   w_pop_n;

  assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};

  // Issue is blocked during reset, while halted, during a redirect cycle and
  // whenever queued plus outstanding entries already fill the queue.
  assign imem_req_valid = !reset && !r_halted && !redirect_valid && (w_occupancy < QDEPTH_W);
  assign imem_req_addr  = r_fetch_pc;
  assign halted         = r_halted;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_rsp_keep = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop      = dec_valid && dec_ready;
  assign w_next_pc  = {1'b0, r_fetch_pc} + (XLEN+1)'(4);

  assign w_fire_n = {{(CW-1){1'b0}}, w_req_fire};
  assign w_rsp_n  = {{(CW-1){1'b0}}, imem_rsp_valid};
  assign w_keep_n = {{(CW-1){1'b0}}, w_rsp_keep};
  assign w_pop_n  = {{(CW-1){1'b0}}, w_pop};

  assign dec_valid = (r_count != '0);
  assign dec_pc    = r_q_pc[r_q_head];
  assign dec_instr = r_q_instr[r_q_head];

  // Control state: pc sequencing, halt, pointers and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_halted   <= !is_legal({1'b0, RESET_PC});
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_count    <= '0;
      r_f_head   <= '0;
      r_f_tail   <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      // Flush the queue; every request still outstanding after this edge
      // returns stale data and is dropped on arrival.
      r_fetch_pc <= redirect_target;
      r_halted   <= !is_legal({1'b0, redirect_target});
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_count    <= '0;
      r_inflight <= r_inflight - w_rsp_n;
      r_drop     <= r_inflight - w_rsp_n;
      if (imem_rsp_valid) begin
        r_f_head <= r_f_head + 1'b1;
      end
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= w_next_pc[XLEN-1:0];
        r_f_tail   <= r_f_tail + 1'b1;
        if (!is_legal(w_next_pc)) begin
          r_halted <= 1'b1;
        end
      end
      if (imem_rsp_valid) begin
        r_f_head <= r_f_head + 1'b1;
        if (r_drop != '0) begin
          r_drop <= r_drop - 1'b1;
        end
      end
      if (w_rsp_keep) begin
        r_q_tail <= r_q_tail + 1'b1;
      end
      if (w_pop) begin
        r_q_head <= r_q_head + 1'b1;
      end
      r_inflight <= r_inflight + w_fire_n - w_rsp_n;
      r_count    <= r_count + w_keep_n - w_pop_n;
    end
  end

  // Payload storage: issued pcs and {pc, instr} queue entries.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_f_pc[r_f_tail] <= r_fetch_pc;
    end
    if (w_rsp_keep && !reset) begin
      r_q_pc[r_q_tail]    <= r_f_pc[r_f_head];
      r_q_instr[r_q_tail] <= imem_rsp_data;
    end
  end

`ifdef IFU_TRACE_EN
  // Trace of decode handshakes and redirects for simulation logs.
  always @(posedge clk) begin
    if (!reset) begin
      if (w_pop) begin
        $display("[IFU] t=%0t pc=%h instr=%h", $time, dec_pc, dec_instr);
      end
      if (redirect_valid) begin
        $display("[IFU] redirect -> %h", redirect_target);
      end
    end
  end
`else
  // Default build carries no trace logic.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_queue
// Brief    : Directed self-checking bench for ifu_fetch_queue with an
//            in-order, fixed-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic        halted;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int lat = 1;
  int acc_cnt = 0;
  logic [31:0] last_addr = '0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pending[$];

  ifu_fetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .dec_valid       (dec_valid),
    .dec_pc          (dec_pc),
    .dec_instr       (dec_instr),
    .dec_ready       (dec_ready),
    .halted          (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // One clock: record an accepted request, then drive the memory response
  // that becomes due in the following cycle.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      acc_cnt++;
      last_addr = a;
      pending.push_back('{addr: a, due: cyc + lat - 1});
    end
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pending.delete();
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    acc_cnt = 0;
  endtask

  // Steps until dec_valid is seen or the budget expires; returns 1 if seen.
  task automatic wait_dec(input string name, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dec_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL %s_timeout: dec_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    dec_ready       = 1'b1;
    #2;
    nvec++;
    if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    nvec++;
    if (dec_valid !== 1'b0) begin nerr++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    nvec++;
    if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted: got %b expected 0", halted); end
    do_reset();
    #1;
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      nerr++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    logic seen;
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    wait_dec("seq", seen);
    for (int i = 0; i < 26; i++) begin
      nvec++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'(i * 4)) begin
        nerr++;
        $display("FAIL seq_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, dec_valid, dec_pc, 32'(i * 4));
      end
      nvec++;
      if (dec_instr !== (32'hA500_0000 ^ 32'(i * 4))) begin
        nerr++;
        $display("FAIL seq_instr[%0d]: got %h expected %h", i, dec_instr, 32'hA500_0000 ^ 32'(i * 4));
      end
      nvec++;
      if (halted !== (i >= 24)) begin
        nerr++;
        $display("FAIL seq_halted[%0d]: got %b expected %b", i, halted, (i >= 24));
      end
      step();
    end
    nvec++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || halted !== 1'b1) begin
      nerr++;
      $display("FAIL seq_end: got dec_valid=%b req_valid=%b halted=%b expected 0 0 1", dec_valid, imem_req_valid, halted);
    end
  endtask

  task automatic test_backpressure();
    lat = 1;
    dec_ready = 1'b0;
    do_reset();
    repeat (10) step();
    nvec++;
    if (acc_cnt != 4 || last_addr !== 32'h0C) begin
      nerr++;
      $display("FAIL bp_issued: got count=%0d last=%h expected count=4 last=0000000c", acc_cnt, last_addr);
    end
    nvec++;
    if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL bp_req_blocked: got %b expected 0", imem_req_valid); end
    nvec++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
      nerr++;
      $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", dec_valid, dec_pc);
    end
    dec_ready = 1'b1;
    step();
    nvec++;
    if (dec_pc !== 32'h04) begin nerr++; $display("FAIL bp_next_head: got %h expected 00000004", dec_pc); end
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      nerr++;
      $display("FAIL bp_resume: got valid=%b addr=%h expected valid=1 addr=00000010", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_drop();
    logic seen;
    lat = 3;
    dec_ready = 1'b1;
    do_reset();
    repeat (3) step();
    nvec++;
    if (acc_cnt != 3) begin nerr++; $display("FAIL rd_inflight: got %0d requests expected 3", acc_cnt); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    #1;
    nvec++;
    if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL rd_req_forced: got %b expected 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      nerr++;
      $display("FAIL rd_target_req: got valid=%b addr=%h expected valid=1 addr=00000040", imem_req_valid, imem_req_addr);
    end
    wait_dec("rd", seen);
    if (seen) begin
      nvec++;
      if (dec_pc !== 32'h40 || dec_instr !== 32'hA500_0040) begin
        nerr++;
        $display("FAIL rd_first_dec: got pc=%h instr=%h expected pc=00000040 instr=a5000040", dec_pc, dec_instr);
      end
    end
  endtask

  task automatic test_halt_window();
    logic seen;
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    step();
    redirect_valid = 1'b0;
    #1;
    nvec++;
    if (halted !== 1'b1 || imem_req_valid !== 1'b0) begin
      nerr++;
      $display("FAIL halt_range: got halted=%b req_valid=%b expected 1 0", halted, imem_req_valid);
    end
    repeat (3) step();
    nvec++;
    if (acc_cnt != 0) begin nerr++; $display("FAIL halt_no_issue: got %0d requests expected 0", acc_cnt); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h22;
    step();
    redirect_valid = 1'b0;
    #1;
    nvec++;
    if (halted !== 1'b1) begin nerr++; $display("FAIL halt_misaligned: got %b expected 1", halted); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    step();
    redirect_valid = 1'b0;
    #1;
    nvec++;
    if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20) begin
      nerr++;
      $display("FAIL halt_resume: got halted=%b valid=%b addr=%h expected 0 1 00000020", halted, imem_req_valid, imem_req_addr);
    end
    wait_dec("halt", seen);
    if (seen) begin
      nvec++;
      if (dec_pc !== 32'h20) begin nerr++; $display("FAIL halt_first_dec: got %h expected 00000020", dec_pc); end
    end
  endtask

  task automatic test_back_to_back();
    logic seen;
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    step();
    step();
    nvec++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || imem_rsp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_setup: got dec_valid=%b pc=%h rsp=%b expected 1 00000000 1", dec_valid, dec_pc, imem_rsp_valid);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h30;
    step();
    redirect_valid = 1'b0;
    #1;
    nvec++;
    if (dec_valid !== 1'b0) begin nerr++; $display("FAIL b2b_empty: got dec_valid=%b expected 0", dec_valid); end
    wait_dec("b2b", seen);
    if (seen) begin
      nvec++;
      if (dec_pc !== 32'h30) begin nerr++; $display("FAIL b2b_next_dec: got %h expected 00000030", dec_pc); end
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    repeat (5) step();
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || halted !== 1'b0) begin
      nerr++;
      $display("FAIL areset_outputs: got dec_valid=%b req_valid=%b halted=%b expected 0 0 0", dec_valid, imem_req_valid, halted);
    end
    pending.delete();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    acc_cnt = 0;
    #1;
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      nerr++;
      $display("FAIL areset_restart: got valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
    wait_dec("areset", seen);
    if (seen) begin
      nvec++;
      if (dec_pc !== 32'h0) begin nerr++; $display("FAIL areset_first_dec: got %h expected 00000000", dec_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_halt_window();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
